// File: rtl/spart_bus_arbiter.sv
// Two-master round-robin arbiter in front of the SPART processor-side bus, with
// a one-cycle turnaround between owners, an owner lock and a starvation timeout.
module spart_bus_arbiter #(
  parameter int GRANT_TIMEOUT = 64,
  parameter int TOW           = $clog2(GRANT_TIMEOUT)
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       m0_req,
  input  logic       m0_lock,
  output logic       m0_gnt,
  input  logic       m0_iocs,
  input  logic       m0_iorw,
  input  logic [1:0] m0_ioaddr,
  input  logic [7:0] m0_wdata,
  output logic [7:0] m0_rdata,

  input  logic       m1_req,
  input  logic       m1_lock,
  output logic       m1_gnt,
  input  logic       m1_iocs,
  input  logic       m1_iorw,
  input  logic [1:0] m1_ioaddr,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m1_rdata,

  input  logic       s_rda,
  input  logic       s_tbr,
  output logic       m_rda,
  output logic       m_tbr,
  output logic       s_iocs,
  output logic       s_iorw,
  output logic [1:0] s_ioaddr,
  inout  wire  [7:0] s_databus,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

  localparam logic [TOW-1:0] TO_MAX = TOW'(GRANT_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           owner_q, owner_d;
  logic [TOW-1:0] cnt_q, cnt_d;

  logic           timeout0, timeout1;
  logic           drv_en;
  logic [7:0]     drv_data;

  // The hold limit only matters while the other master is waiting and the owner is unlocked.
  assign timeout0 = m1_req && !m0_lock && (cnt_q == TO_MAX);
  assign timeout1 = m0_req && !m1_lock && (cnt_q == TO_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, TURN: begin
        if (m0_req && (!m1_req || !ptr_q)) begin
          state_d = GNT0;
          owner_d = 1'b0;
          cnt_d   = '0;
        end else if (m1_req) begin
          state_d = GNT1;
          owner_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!m0_req || timeout0) begin
          state_d = TURN;
          ptr_d   = 1'b1;
          cnt_d   = '0;
        end else if (!m1_req) begin
          cnt_d = '0;
        end else if (!m0_lock) begin
          cnt_d = cnt_q + TOW'(1);
        end
      end
      GNT1: begin
        if (!m1_req || timeout1) begin
          state_d = TURN;
          ptr_d   = 1'b0;
          cnt_d   = '0;
        end else if (!m0_req) begin
          cnt_d = '0;
        end else if (!m1_lock) begin
          cnt_d = cnt_q + TOW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt = (state_q == GNT0);
  assign m1_gnt = (state_q == GNT1);
  assign busy   = m0_gnt | m1_gnt;
  assign owner  = owner_q;

  // Only the owner's strobes reach the SPART; otherwise the bus parks as an idle read.
  always_comb begin
    s_iocs   = 1'b0;
    s_iorw   = 1'b1;
    s_ioaddr = 2'b00;
    drv_en   = 1'b0;
    drv_data = 8'h00;
    if (m0_gnt) begin
      s_iocs   = m0_iocs;
      s_iorw   = m0_iorw;
      s_ioaddr = m0_ioaddr;
      drv_en   = m0_iocs && !m0_iorw;
      drv_data = m0_wdata;
    end else if (m1_gnt) begin
      s_iocs   = m1_iocs;
      s_iorw   = m1_iorw;
      s_ioaddr = m1_ioaddr;
      drv_en   = m1_iocs && !m1_iorw;
      drv_data = m1_wdata;
    end
  end

  assign s_databus = drv_en ? drv_data : 8'hzz;

  assign m0_rdata = (m0_gnt && m0_iorw) ? s_databus : 8'h00;
  assign m1_rdata = (m1_gnt && m1_iorw) ? s_databus : 8'h00;

  assign m_rda = s_rda;
  assign m_tbr = s_tbr;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: a cycle table for arbitration order plus
// hand sequences for writes, reads, handoff, timeout, lock and async reset.
module tb_spart_bus_arbiter;

  localparam int GT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m0_lock, m0_iocs, m0_iorw;
  logic [1:0] m0_ioaddr;
  logic [7:0] m0_wdata;
  logic       m0_gnt;
  logic [7:0] m0_rdata;
  logic       m1_req, m1_lock, m1_iocs, m1_iorw;
  logic [1:0] m1_ioaddr;
  logic [7:0] m1_wdata;
  logic       m1_gnt;
  logic [7:0] m1_rdata;
  logic       s_rda, s_tbr, m_rda, m_tbr;
  logic       s_iocs, s_iorw;
  logic [1:0] s_ioaddr;
  wire  [7:0] s_databus;
  logic       busy, owner;

  // Bench-side SPART model: drives read data, or a parking value of 00 to expose stray drives.
  logic       sp_en;
  logic [7:0] sp_val;
  assign s_databus = sp_en ? sp_val : 8'hzz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spart_bus_arbiter #(.GRANT_TIMEOUT(GT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_iocs(m0_iocs),
    .m0_iorw(m0_iorw), .m0_ioaddr(m0_ioaddr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_iocs(m1_iocs),
    .m1_iorw(m1_iorw), .m1_ioaddr(m1_ioaddr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_rda(s_rda), .s_tbr(s_tbr), .m_rda(m_rda), .m_tbr(m_tbr),
    .s_iocs(s_iocs), .s_iorw(s_iorw), .s_ioaddr(s_ioaddr), .s_databus(s_databus),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic r0, r1;
    logic g0, g1, own;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_req = 0; m0_lock = 0; m0_iocs = 0; m0_iorw = 1; m0_ioaddr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_iocs = 0; m1_iorw = 1; m1_ioaddr = 0; m1_wdata = 0;
    s_rda = 0; s_tbr = 0; sp_en = 1; sp_val = 8'h00;
  endtask

  task automatic do_reset;
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int n;
    //            r0 r1  g0 g1 own
    tbl[0]  = '{1, 0,  1, 0, 0};
    tbl[1]  = '{1, 0,  1, 0, 0};
    tbl[2]  = '{0, 0,  0, 0, 0};
    tbl[3]  = '{0, 0,  0, 0, 0};
    tbl[4]  = '{1, 1,  0, 1, 1};
    tbl[5]  = '{0, 1,  0, 1, 1};
    tbl[6]  = '{0, 0,  0, 0, 1};
    tbl[7]  = '{1, 1,  1, 0, 0};
    tbl[8]  = '{0, 1,  0, 0, 0};
    tbl[9]  = '{0, 1,  0, 1, 1};
    tbl[10] = '{1, 1,  0, 1, 1};
    tbl[11] = '{1, 0,  0, 0, 1};
    tbl[12] = '{1, 0,  1, 0, 0};
    tbl[13] = '{0, 0,  0, 0, 0};
    tbl[14] = '{1, 0,  1, 0, 0};
    tbl[15] = '{0, 0,  0, 0, 0};
    tbl[16] = '{0, 0,  0, 0, 0};

    do_reset();
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_s_iocs", s_iocs, 0);
    chk("rst_s_iorw", s_iorw, 1);
    chk("rst_s_ioaddr", s_ioaddr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);

    // Arbitration order table
    for (int i = 0; i < 17; i++) begin
      m0_req = tbl[i].r0;
      m1_req = tbl[i].r1;
      step();
      chk($sformatf("tbl%0d_m0_gnt", i), m0_gnt, tbl[i].g0);
      chk($sformatf("tbl%0d_m1_gnt", i), m1_gnt, tbl[i].g1);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].g0 | tbl[i].g1);
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
    end

    // m0 write reaches the SPART; m1's inputs stay off the bus
    do_reset();
    m0_req = 1;
    m1_iocs = 1; m1_iorw = 0; m1_ioaddr = 2'b01; m1_wdata = 8'h11;
    step();
    chk("wr_m0_gnt", m0_gnt, 1);
    m0_ioaddr = 2'b10; m0_wdata = 8'hA3; m0_iocs = 1; m0_iorw = 0; sp_en = 0;
    #1;
    chk("wr_s_ioaddr", s_ioaddr, 2'b10);
    chk("wr_s_iocs", s_iocs, 1);
    chk("wr_s_iorw", s_iorw, 0);
    chk("wr_s_databus", s_databus, 8'hA3);
    chk("wr_m1_gnt", m1_gnt, 0);

    // Handoff with turnaround: both request together, m0 wins, then releases
    do_reset();
    m0_req = 1; m1_req = 1;
    m0_iocs = 1; m0_iorw = 0; m0_wdata = 8'hA3;
    step();
    chk("ho_m0_gnt", m0_gnt, 1);
    chk("ho_m1_gnt_wait", m1_gnt, 0);
    m0_req = 0;
    step();
    chk("ho_turn_m0_gnt", m0_gnt, 0);
    chk("ho_turn_m1_gnt", m1_gnt, 0);
    chk("ho_turn_databus", s_databus, 8'h00);
    chk("ho_turn_s_iocs", s_iocs, 0);
    step();
    chk("ho_m1_gnt", m1_gnt, 1);
    chk("ho_owner", owner, 1);

    // Timeout preempts an unlocked owner after GT granted cycles
    do_reset();
    m0_req = 1; m1_req = 1;
    step();
    chk("to_m0_gnt", m0_gnt, 1);
    n = 1;
    while (m0_gnt && n < 20) begin
      step();
      if (m0_gnt) n++;
    end
    chk("to_granted_cycles", n, GT);
    chk("to_turn_m1_gnt", m1_gnt, 0);
    chk("to_turn_busy", busy, 0);
    step();
    chk("to_m1_gnt", m1_gnt, 1);
    chk("to_owner", owner, 1);

    // Lock suppresses the timeout for as long as it is held
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (m0_gnt && !m1_gnt) n++;
      step();
    end
    chk("lk_held_cycles", n, 20);
    m0_req = 0; m0_lock = 0;
    step();
    chk("lk_turn_m0_gnt", m0_gnt, 0);
    chk("lk_turn_m1_gnt", m1_gnt, 0);
    step();
    chk("lk_m1_gnt", m1_gnt, 1);

    // m1 reads: SPART drives the bus, arbiter must not
    m1_iocs = 1; m1_iorw = 1; m1_ioaddr = 2'b11; m1_wdata = 8'hFF;
    m0_iocs = 1; m0_iorw = 1; m0_wdata = 8'hFF;
    sp_en = 1; sp_val = 8'h5A;
    #1;
    chk("rd_m1_rdata", m1_rdata, 8'h5A);
    chk("rd_m0_rdata", m0_rdata, 8'h00);
    chk("rd_s_databus", s_databus, 8'h5A);
    chk("rd_s_ioaddr", s_ioaddr, 2'b11);
    s_rda = 1; s_tbr = 0;
    #1;
    chk("rd_m_rda_hi", m_rda, 1);
    chk("rd_m_tbr_lo", m_tbr, 0);
    s_rda = 0; s_tbr = 1;
    #1;
    chk("rd_m_rda_lo", m_rda, 0);
    chk("rd_m_tbr_hi", m_tbr, 1);

    // Asynchronous reset in the middle of an m1 write
    m1_iorw = 0; m1_wdata = 8'h3C; sp_en = 0;
    #1;
    chk("ar_pre_databus", s_databus, 8'h3C);
    rst = 0; sp_en = 1; sp_val = 8'h00;
    #1;
    chk("ar_m1_gnt", m1_gnt, 0);
    chk("ar_s_iocs", s_iocs, 0);
    chk("ar_databus", s_databus, 8'h00);
    chk("ar_busy", busy, 0);
    chk("ar_owner", owner, 0);
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    rst = 1;
    step();
    chk("ar_post_m0_gnt", m0_gnt, 1);
    chk("ar_post_m1_gnt", m1_gnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
